retire_trace_emitter: RTL and testbench
=======================================

// Module: retire_trace_emitter
// PURPOSE
//  In-processor producer of the commit trace and performance counters.
//  Samples WB/MEM-stage retire signals each cycle and packs them into one record per retiring cycle.
//  Buffers records in a FIFO and streams them out over a valid/ready port to a debug/trace consumer.
//  Keeps cycle, instruction and I/D cache req/hit counters. Sits beside p0 and is clocked by c0.
// PARAMETERS
//  DEPTH   8   FIFO entries (power of 2, >=2)
//  CNT_W   32  width of each performance counter
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous reset, active-high
//  reg_write    in   1   WB register write this cycle
//  write_reg    in   3   WB destination register
//  write_data   in   16  WB write data
//  mem_read     in   1   MEM-stage load
//  mem_write    in   1   MEM-stage store
//  mem_addr     in   16  MEM-stage address
//  mem_wdata    in   16  store data
//  mem_rdata    in   16  load data
//  halt         in   1   halt in WB
//  icache_req / icache_hit / dcache_req / dcache_hit  in 1 each  cache events
//  trace_ready  in   1   consumer accepts the head record
//  trace_valid  out  1   head record valid
//  trace_flags  out  4   {halt,mem_write,mem_read,reg_write}
//  trace_reg    out  3   write_reg
//  trace_wdata  out  16  write_data
//  trace_addr   out  16  mem_addr
//  trace_mdata  out  16  mem_wdata if mem_write, else mem_rdata
//  overflow     out  1   sticky: a record was dropped
//  done         out  1   halt record has been consumed
//  cnt_sel      in   3   0 cycles,1 insts,2 ihit,3 ireq,4 dhit,5 dreq,6 drops,7 reads 0
//  cnt_data     out  CNT_W  selected counter (combinational from cnt_sel)
// BEHAVIOUR
//  - Reset: FIFO empty, trace_valid=0, all trace_* fields 0, overflow=0, done=0, counters 0, state RUN.
//  - Event cycle: any of reg_write|mem_read|mem_write|halt, sampled in RUN only.
//  - One record per event cycle; first-word-fall-through, visible on trace_valid the cycle after sampling.
//  - Transfer occurs on trace_valid&trace_ready. Outputs hold stable while valid&!ready.
//  - Full FIFO + event: record accepted if a pop occurs in the same cycle. Otherwise it is dropped,
//    overflow is set (sticky until reset) and the drop counter increments.
//  - Empty FIFO: push and pop in the same cycle cannot occur (valid=0).
//  - Pointers wrap modulo DEPTH. A separate count distinguishes full from empty.
//  - FSM: RUN -> DRAIN on a sampled halt. A dropped halt record still moves to DRAIN.
//    DRAIN: no sampling; counters frozen; FIFO pops normally.
//    DRAIN -> DONE when the FIFO becomes empty; done=1 in DONE. DONE is held until rst.
//  - Counters (RUN, including the halt cycle): cycles +1 every cycle;
//    insts +1 if halt|reg_write|mem_write; cache counters +1 on their input.
//    Counters saturate at 2^CNT_W-1, no wrap.
//  - rst asserted mid-operation: immediate clear, in-flight records are discarded.
// CONFIGURATION
//  TRACE_PERF_CNT_EN defined: counters and cnt_data implemented as above.
//  Not defined: no counter flops; cnt_data ties to 0. FIFO, overflow, FSM and done are unchanged.
// TESTING
//  1) Load cycle: reg_write=1,write_reg=3,write_data=0x1234,mem_read=1,mem_addr=0x0040,mem_rdata=0x1234, ready=1
//     -> next cycle valid=1,flags=4'b0011,reg=3,addr=0x0040,mdata=0x1234; one beat only.
//  2) ready=0, 8 store events at DEPTH=8 then a 9th -> 8 records held, overflow=1, drops=1;
//     the 9th is never emitted. Raise ready -> 8 records emitted in order.
//  3) Full FIFO, event with ready=1 in the same cycle -> no drop, count stays 8, overflow stays 0.
//  4) halt after 5 retiring instructions over 12 cycles with ready=0 -> further events ignored, cycles=12,
//    insts=6. Raise ready -> after the last pop done=1; halt record flags=4'b1000.
//  5) icache_req+icache_hit each cycle for 10 cycles, dcache_req 3 cycles, 1 dcache_hit
//    -> ihit=10, ireq=10, dreq=3, dhit=1. Without TRACE_PERF_CNT_EN, cnt_data=0 for all selects.
//  6) Async rst pulse mid-cycle with 4 records queued -> valid=0, overflow=0, counters 0, immediately.

Source files
------------

// File: rtl/retire_trace_emitter.sv
// ---------------------------------------------------------------------------
// retire_trace_emitter
//   Commit-trace producer and performance counter block.
//   Each cycle the WB/MEM-stage retire signals are sampled. A cycle with any
//   retire event is packed into one record, which is pushed into a
//   first-word-fall-through FIFO and streamed out over a valid/ready port.
//   A sampled halt stops sampling (DRAIN). Once the FIFO has fully drained
//   the block parks in DONE and raises done until reset.
//
//   Optional feature macro: TRACE_PERF_CNT_EN
//     defined   : cycle/inst/cache/drop counters, readable via cnt_sel/cnt_data
//     undefined : no counter flops, cnt_data reads 0
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   CNT_W  performance counter width
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   reg_write..mem_rdata  WB/MEM retire information
//   halt                  halt instruction in WB
//   icache_*/dcache_*     cache request/hit events
//   trace_ready           consumer accepts the head record
//   trace_valid, trace_*  head record (all fields 0 while FIFO is empty)
//   overflow              sticky: a record was dropped on a full FIFO
//   done                  halt record has been consumed and FIFO is empty
//   cnt_sel, cnt_data     counter select (0 cycles,1 insts,2 ihit,3 ireq,
//                         4 dhit,5 dreq,6 drops,7 zero) and selected value
// ---------------------------------------------------------------------------
module retire_trace_emitter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             halt,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             trace_ready,
  output logic             trace_valid,
  output logic [3:0]       trace_flags,
  output logic [2:0]       trace_reg,
  output logic [15:0]      trace_wdata,
  output logic [15:0]      trace_addr,
  output logic [15:0]      trace_mdata,
  output logic             overflow,
  output logic             done,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_data
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  flags;
    logic [2:0]  rd;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
  } traceRec_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t        state, stateNext;
  traceRec_t     fifoMem [DEPTH];
  traceRec_t     inRec, headRec;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count, countNext;
  logic          isRun, isEvent, isFull, doPop, doPush, doDrop;

  assign isRun   = (state == RUN);
  assign isEvent = isRun && (reg_write || mem_read || mem_write || halt);
  assign isFull  = (count == (PW+1)'(DEPTH));

  assign trace_valid = (count != '0);
  assign doPop       = trace_valid && trace_ready;
  // A full FIFO still takes the record when the head leaves in the same cycle.
  assign doPush      = isEvent && (!isFull || doPop);
  assign doDrop      = isEvent && isFull && !doPop;

  always_comb begin
    inRec       = '0;
    inRec.flags = {halt, mem_write, mem_read, reg_write};
    inRec.rd    = write_reg;
    inRec.wdata = write_data;
    inRec.addr  = mem_addr;
    inRec.mdata = mem_write ? mem_wdata : mem_rdata;
  end

  always_comb begin
    countNext = count;
    case ({doPush, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Storage is datapath only; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= inRec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      if (doDrop) overflow <= 1'b1;
    end
  end

  // Fields read zero whenever nothing is valid, including straight after reset.
  assign headRec     = trace_valid ? fifoMem[rdPtr] : '0;
  assign trace_flags = headRec.flags;
  assign trace_reg   = headRec.rd;
  assign trace_wdata = headRec.wdata;
  assign trace_addr  = headRec.addr;
  assign trace_mdata = headRec.mdata;

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      // A halt moves to DRAIN even if its own record was dropped.
      RUN:     if (isEvent && halt)    stateNext = DRAIN;
      DRAIN:   if (countNext == '0)    stateNext = DONE;
      DONE:    stateNext = DONE;
      default: stateNext = RUN;
    endcase
  end

  assign done = (state == DONE);

`ifdef TRACE_PERF_CNT_EN
  // Slot 7 never increments, so it always reads 0.
  logic [7:0][CNT_W-1:0] perfCnt;
  logic [7:0]            perfInc;

  assign perfInc = {1'b0, doDrop, dcache_req, dcache_hit, icache_req, icache_hit,
                    (halt || reg_write || mem_write), 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfCnt <= '0;
    end else if (isRun) begin
      for (int i = 0; i < 8; i++) begin
        if (perfInc[i] && (perfCnt[i] != '1)) perfCnt[i] <= perfCnt[i] + 1'b1;
      end
    end
  end

  assign cnt_data = perfCnt[cnt_sel];
`else
  logic unusedPerf;
  assign unusedPerf = ^{icache_req, icache_hit, dcache_req, dcache_hit, cnt_sel};
  assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_retire_trace_emitter.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_emitter
//   Directed bench for retire_trace_emitter (DEPTH=8, CNT_W=4 so counter
//   saturation is reachable). A queue-based model tracks what the trace port,
//   overflow, done and counters must show; a compare process checks the DUT
//   against it on every falling edge. Directed scenarios add literal checks.
//   Stimulus is driven 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_retire_trace_emitter;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reg_write, mem_read, mem_write, halt;
  logic [2:0] write_reg;
  logic [15:0] write_data, mem_addr, mem_wdata, mem_rdata;
  logic icache_req, icache_hit, dcache_req, dcache_hit, trace_ready;
  logic trace_valid, overflow, done;
  logic [3:0] trace_flags;
  logic [2:0] trace_reg;
  logic [15:0] trace_wdata, trace_addr, trace_mdata;
  logic [2:0] cnt_sel = 3'd0;
  logic [CNT_W-1:0] cnt_data;

  always #5 clk = ~clk;

  retire_trace_emitter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_flags(trace_flags), .trace_reg(trace_reg), .trace_wdata(trace_wdata),
    .trace_addr(trace_addr), .trace_mdata(trace_mdata),
    .overflow(overflow), .done(done), .cnt_sel(cnt_sel), .cnt_data(cnt_data)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [3:0]  flags;
    logic [2:0]  rd;
    logic [15:0] wd;
    logic [15:0] ad;
    logic [15:0] md;
  } rec_t;

  rec_t mq[$];
  int   mCnt [8];
  bit   mOvf  = 1'b0;
  int   mMode = 0;   // 0 sampling, 1 draining, 2 finished

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mOvf  = 1'b0;
      mMode = 0;
      foreach (mCnt[i]) mCnt[i] = 0;
    end else begin
      bit   ev, pop, fullBefore, drop;
      rec_t r;
      ev         = (mMode == 0) && (reg_write || mem_read || mem_write || halt);
      fullBefore = (mq.size() == DEPTH);
      pop        = (mq.size() != 0) && trace_ready;
      drop       = ev && fullBefore && !pop;
      if (mMode == 0) begin
        if (mCnt[0] < MAXC) mCnt[0]++;
        if ((halt || reg_write || mem_write) && mCnt[1] < MAXC) mCnt[1]++;
        if (icache_hit && mCnt[2] < MAXC) mCnt[2]++;
        if (icache_req && mCnt[3] < MAXC) mCnt[3]++;
        if (dcache_hit && mCnt[4] < MAXC) mCnt[4]++;
        if (dcache_req && mCnt[5] < MAXC) mCnt[5]++;
        if (drop && mCnt[6] < MAXC) mCnt[6]++;
      end
      if (pop) void'(mq.pop_front());
      if (ev) begin
        if (drop) mOvf = 1'b1;
        else begin
          r.flags = {halt, mem_write, mem_read, reg_write};
          r.rd    = write_reg;
          r.wd    = write_data;
          r.ad    = mem_addr;
          r.md    = mem_write ? mem_wdata : mem_rdata;
          mq.push_back(r);
        end
      end
      if (mMode == 0 && ev && halt) mMode = 1;
      else if (mMode == 1 && mq.size() == 0) mMode = 2;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("valid", 32'(trace_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("flags", 32'(trace_flags), 32'(mq[0].flags));
      chk("reg",   32'(trace_reg),   32'(mq[0].rd));
      chk("wdata", 32'(trace_wdata), 32'(mq[0].wd));
      chk("addr",  32'(trace_addr),  32'(mq[0].ad));
      chk("mdata", 32'(trace_mdata), 32'(mq[0].md));
    end else begin
      chk("idle_fields", 32'({trace_flags, trace_reg, trace_wdata}), 32'd0);
      chk("idle_addr_mdata", {trace_addr, trace_mdata}, 32'd0);
    end
    chk("overflow", 32'(overflow), 32'(mOvf));
    chk("done",     32'(done),     32'(mMode == 2));
`ifdef TRACE_PERF_CNT_EN
    chk("cnt_data", 32'(cnt_data), 32'(mCnt[cnt_sel]));
`else
    chk("cnt_data_off", 32'(cnt_data), 32'd0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIns();
    reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0; mem_rdata = 0;
    halt = 0; icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic doReset();
    clearIns();
    trace_ready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic store(input int i, input logic [15:0] d);
    mem_write = 1; mem_addr = 16'(i); mem_wdata = d;
    step();
    clearIns();
  endtask

  task automatic readCnt(input logic [2:0] sel, input string name, input int exp);
    cnt_sel = sel;
    #1;
`ifdef TRACE_PERF_CNT_EN
    chk(name, 32'(cnt_data), 32'(exp));
`else
    chk(name, 32'(cnt_data), 32'd0);
`endif
  endtask

  task automatic drainAll(output int beats, output logic [3:0] lastFlags,
                          output logic [15:0] lastMdata);
    beats = 0; lastFlags = 0; lastMdata = 0;
    trace_ready = 1;
    for (int k = 0; k < 40 && trace_valid; k++) begin
      lastFlags = trace_flags;
      lastMdata = trace_mdata;
      beats++;
      step();
    end
    if (trace_valid) chk("drain_timeout", 32'(trace_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int b;
    logic [3:0] lf;
    logic [15:0] lm;
    clearIns();
    trace_ready = 0;
    #1;
    doReset();

    // reset state
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 1) single load beat
    reg_write = 1; write_reg = 3; write_data = 16'h1234;
    mem_read = 1; mem_addr = 16'h0040; mem_rdata = 16'h1234; trace_ready = 1;
    step();
    clearIns();
    chk("t1_valid", 32'(trace_valid), 32'd1);
    chk("t1_flags", 32'(trace_flags), 32'b0011);
    chk("t1_reg",   32'(trace_reg),   32'd3);
    chk("t1_addr",  32'(trace_addr),  32'h0040);
    chk("t1_mdata", 32'(trace_mdata), 32'h1234);
    step();
    chk("t1_one_beat", 32'(trace_valid), 32'd0);

    // 2) fill with ready low, 9th dropped, then drain in order
    doReset();
    for (int i = 0; i < 8; i++) store(i, 16'(16'h0100 + i));
    chk("t2_no_ovf_at_full", 32'(overflow), 32'd0);
    store(8, 16'hDEAD);
    chk("t2_overflow", 32'(overflow), 32'd1);
    readCnt(3'd6, "t2_drops", 1);
    trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_beat_valid", 32'(trace_valid), 32'd1);
      chk("t2_beat_mdata", 32'(trace_mdata), 32'(16'h0100 + i));
      chk("t2_beat_flags", 32'(trace_flags), 32'b0100);
      step();
    end
    chk("t2_ninth_never", 32'(trace_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // 3) full FIFO, event with simultaneous pop
    doReset();
    for (int i = 0; i < 8; i++) store(i, 16'(16'h0200 + i));
    mem_write = 1; mem_addr = 16'h0009; mem_wdata = 16'hBEEF; trace_ready = 1;
    step();
    clearIns();
    trace_ready = 0;
    chk("t3_overflow", 32'(overflow), 32'd0);
    drainAll(b, lf, lm);
    chk("t3_beats", 32'(b), 32'd8);
    chk("t3_last", 32'(lm), 32'hBEEF);

    // 4) halt after 5 retiring instructions over 12 cycles
    doReset();
    for (int i = 0; i < 11; i++) begin
      reg_write = (i % 2 == 0) && (i < 10);
      write_reg = 3'(i);
      write_data = 16'(i);
      step();
    end
    clearIns();
    halt = 1;
    step();
    clearIns();
    reg_write = 1; mem_write = 1;
    step(); step(); step();
    clearIns();
    readCnt(3'd0, "t4_cycles", 12);
    readCnt(3'd1, "t4_insts", 6);
    chk("t4_not_done", 32'(done), 32'd0);
    drainAll(b, lf, lm);
    chk("t4_beats", 32'(b), 32'd6);
    chk("t4_halt_flags", 32'(lf), 32'b1000);
    chk("t4_done", 32'(done), 32'd1);
    step();
    chk("t4_done_held", 32'(done), 32'd1);

    // 5) cache counters and saturation
    doReset();
    for (int i = 0; i < 10; i++) begin
      icache_req = 1; icache_hit = 1;
      dcache_req = (i < 3); dcache_hit = (i == 0);
      step();
    end
    clearIns();
    readCnt(3'd2, "t5_ihit", 10);
    readCnt(3'd3, "t5_ireq", 10);
    readCnt(3'd4, "t5_dhit", 1);
    readCnt(3'd5, "t5_dreq", 3);
    readCnt(3'd7, "t5_sel7", 0);
    for (int i = 0; i < 10; i++) step();
    readCnt(3'd0, "t5_cycles_sat", MAXC);
    readCnt(3'd1, "t5_insts_zero", 0);

    // 6) async reset mid-cycle with 4 records queued and overflow set
    doReset();
    for (int i = 0; i < 9; i++) store(i, 16'(16'h0300 + i));
    trace_ready = 1;
    step(); step(); step(); step();
    trace_ready = 0;
    chk("t6_queued", 32'(trace_valid), 32'd1);
    chk("t6_ovf_before", 32'(overflow), 32'd1);
    cnt_sel = 3'd0;
    #2;
    rst = 1;
    #1;
    chk("t6_valid", 32'(trace_valid), 32'd0);
    chk("t6_overflow", 32'(overflow), 32'd0);
    chk("t6_mdata", 32'(trace_mdata), 32'd0);
    chk("t6_cnt", 32'(cnt_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    step();
    chk("t6_after_valid", 32'(trace_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
